// File: rtl/node_ingress_router.sv
// Ingress stage ahead of master_spi: three one-entry source slots, a round-robin
// drain arbiter, destination decode and a registered output stage.
module node_ingress_router #(
  parameter int                    width      = 32,
  parameter int                    addr_width = 8,
  parameter logic [addr_width-1:0] NODE_ADDR  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             check_from_left,
  input  logic [width-1:0] instr_from_left,
  input  logic             check_from_right,
  input  logic [width-1:0] instr_from_right,
  input  logic             check_local,
  input  logic [width-1:0] instr_local,
  output logic             new_instr,
  output logic [1:0]       enable,
  output logic [width-1:0] in_instr,
  output logic             busy,
  output logic [7:0]       drop_count
);

  typedef enum logic [1:0] {
    SRC_LEFT  = 2'd0,
    SRC_RIGHT = 2'd1,
    SRC_LOCAL = 2'd2
  } src_e;

  localparam logic [1:0] EN_SELF  = 2'b01;
  localparam logic [1:0] EN_RIGHT = 2'b00;
  localparam logic [1:0] EN_LEFT  = 2'b10;

  logic [2:0]       valid_q, valid_d;
  logic [width-1:0] slot_q [3];
  logic [width-1:0] slot_d [3];
  src_e             ptr_q, ptr_d;

  logic             new_instr_q, new_instr_d;
  logic [1:0]       enable_q, enable_d;
  logic [width-1:0] in_instr_q, in_instr_d;
  logic [7:0]       drop_count_q, drop_count_d;

  logic [2:0]       check;
  logic [width-1:0] instr_in [3];
  logic [2:0]       grant_oh;
  logic             grant_any;
  logic [width-1:0] grant_data;
  logic [addr_width-1:0] dest;
  logic [1:0]       drops;
  logic [8:0]       drop_sum;

  assign check       = {check_local, check_from_right, check_from_left};
  assign instr_in[0] = instr_from_left;
  assign instr_in[1] = instr_from_right;
  assign instr_in[2] = instr_local;

  // Search valid slots in cyclic order starting at the pointer; first hit wins.
  always_comb begin
    grant_oh = 3'b000;
    unique case (ptr_q)
      SRC_RIGHT: begin
        if (valid_q[1])      grant_oh = 3'b010;
        else if (valid_q[2]) grant_oh = 3'b100;
        else if (valid_q[0]) grant_oh = 3'b001;
      end
      SRC_LOCAL: begin
        if (valid_q[2])      grant_oh = 3'b100;
        else if (valid_q[0]) grant_oh = 3'b001;
        else if (valid_q[1]) grant_oh = 3'b010;
      end
      default: begin
        if (valid_q[0])      grant_oh = 3'b001;
        else if (valid_q[1]) grant_oh = 3'b010;
        else if (valid_q[2]) grant_oh = 3'b100;
      end
    endcase
  end

  assign grant_any  = |grant_oh;
  assign grant_data = ({width{grant_oh[0]}} & slot_q[0])
                    | ({width{grant_oh[1]}} & slot_q[1])
                    | ({width{grant_oh[2]}} & slot_q[2]);
  assign dest       = grant_data[width-1 -: addr_width];

  always_comb begin
    ptr_d = ptr_q;
    if (grant_oh[0])      ptr_d = SRC_RIGHT;
    else if (grant_oh[1]) ptr_d = SRC_LOCAL;
    else if (grant_oh[2]) ptr_d = SRC_LEFT;
  end

  // A slot being drained on this edge can accept the new arrival at the same time.
  always_comb begin
    valid_d = valid_q;
    drops   = 2'd0;
    for (int i = 0; i < 3; i++) begin
      slot_d[i] = slot_q[i];
      if (grant_oh[i]) valid_d[i] = 1'b0;
      if (check[i]) begin
        if (!valid_q[i] || grant_oh[i]) begin
          valid_d[i] = 1'b1;
          slot_d[i]  = instr_in[i];
        end else begin
          drops = drops + 2'd1;
        end
      end
    end
  end

  assign drop_sum     = {1'b0, drop_count_q} + {7'd0, drops};
  assign drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_comb begin
    new_instr_d = 1'b0;
    enable_d    = enable_q;
    in_instr_d  = '0;
    if (grant_any) begin
      new_instr_d = 1'b1;
      in_instr_d  = grant_data;
      if (dest == NODE_ADDR)     enable_d = EN_SELF;
      else if (dest > NODE_ADDR) enable_d = EN_RIGHT;
      else                       enable_d = EN_LEFT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 3'b000;
      ptr_q        <= SRC_LEFT;
      new_instr_q  <= 1'b0;
      enable_q     <= EN_SELF;
      in_instr_q   <= '0;
      drop_count_q <= 8'h00;
      for (int i = 0; i < 3; i++) slot_q[i] <= '0;
    end else begin
      valid_q      <= valid_d;
      ptr_q        <= ptr_d;
      new_instr_q  <= new_instr_d;
      enable_q     <= enable_d;
      in_instr_q   <= in_instr_d;
      drop_count_q <= drop_count_d;
      for (int i = 0; i < 3; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign new_instr  = new_instr_q;
  assign enable     = enable_q;
  assign in_instr   = in_instr_q;
  assign busy       = |valid_q;
  assign drop_count = drop_count_q;

endmodule
